// File: rtl/rect_layer_mixer_pkg.sv
// Shared types and helpers for the rectangle layer mixer.
// Per-layer config is stored at a fixed maximum width so the block can be
// parametrised below these limits without per-instance struct types.
package mixer_pkg;

  localparam int coord_max_width_c = 16;
  localparam int color_max_width_c = 8;
  localparam int mixer_latency_c   = 2;

  typedef struct packed {
    logic [color_max_width_c-1:0] r;
    logic [color_max_width_c-1:0] g;
    logic [color_max_width_c-1:0] b;
  } color_t;

  typedef struct packed {
    logic [coord_max_width_c-1:0] left;
    logic [coord_max_width_c-1:0] right;
    logic [coord_max_width_c-1:0] top;
    logic [coord_max_width_c-1:0] bot;
  } rect_t;

  typedef struct packed {
    rect_t  rect;
    color_t color;
    logic   enable;
  } layer_cfg_t;

  // Strict unsigned interior test; degenerate rectangles fall out naturally.
  function automatic logic rect_hit(input layer_cfg_t cfg,
                                    input logic [coord_max_width_c-1:0] x,
                                    input logic [coord_max_width_c-1:0] y);
    return cfg.enable && (x > cfg.rect.left) && (x < cfg.rect.right) &&
           (y > cfg.rect.top) && (y < cfg.rect.bot);
  endfunction

endpackage

// File: rtl/rect_layer_mixer_layer_slot.sv
// One rectangle layer: shadow/active config registers, write decode and the
// registered stage-1 hit bit.
module layer_slot
  import mixer_pkg::*;
#(
  parameter int layer_idx_p   = 0,
  parameter int coord_width_p = 10,
  parameter int color_width_p = 4,
  parameter int sel_width_p   = 2
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       frame_i,
  input  logic                       cfg_write_i,
  input  logic [sel_width_p-1:0]     cfg_layer_i,
  input  logic [coord_width_p-1:0]   cfg_left_i,
  input  logic [coord_width_p-1:0]   cfg_right_i,
  input  logic [coord_width_p-1:0]   cfg_top_i,
  input  logic [coord_width_p-1:0]   cfg_bot_i,
  input  logic [3*color_width_p-1:0] cfg_color_i,
  input  logic                       cfg_enable_i,
  input  logic [coord_width_p-1:0]   sx_i,
  input  logic [coord_width_p-1:0]   sy_i,
  output logic                       hit_o,
  output color_t                     color_o
);

  layer_cfg_t shadow_r;
  layer_cfg_t active_r;
  layer_cfg_t wr_cfg_s;
  logic       wr_sel_s;

  // Widen the incoming write to storage format and decode the target layer.
  always_comb begin
    wr_cfg_s            = '0;
    wr_cfg_s.rect.left  = coord_max_width_c'(cfg_left_i);
    wr_cfg_s.rect.right = coord_max_width_c'(cfg_right_i);
    wr_cfg_s.rect.top   = coord_max_width_c'(cfg_top_i);
    wr_cfg_s.rect.bot   = coord_max_width_c'(cfg_bot_i);
    wr_cfg_s.color.r    = color_max_width_c'(cfg_color_i[3*color_width_p-1 -: color_width_p]);
    wr_cfg_s.color.g    = color_max_width_c'(cfg_color_i[2*color_width_p-1 -: color_width_p]);
    wr_cfg_s.color.b    = color_max_width_c'(cfg_color_i[color_width_p-1:0]);
    wr_cfg_s.enable     = cfg_enable_i;
    wr_sel_s            = cfg_write_i && (cfg_layer_i == sel_width_p'(layer_idx_p));
  end

  // Shadow set: last accepted write before a commit wins.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      shadow_r <= '0;
    end else if (wr_sel_s) begin
      shadow_r <= wr_cfg_s;
    end
  end

  // Active set: whole-layer copy at the frame strobe, never partially.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      active_r <= '0;
    end else if (frame_i) begin
      active_r <= shadow_r;
    end
  end

  // Stage-1 hit bit for the current pixel against the active rectangle.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      hit_o <= 1'b0;
    end else begin
      hit_o <= rect_hit(active_r, coord_max_width_c'(sx_i), coord_max_width_c'(sy_i));
    end
  end

  assign color_o = active_r.color;

endmodule

// File: rtl/rect_layer_mixer.sv
// Fixed-priority rectangle compositor between the DVI timing controller and
// the output pads, with per-frame collision reporting.
module rect_layer_mixer
  import mixer_pkg::*;
#(
  parameter int layers_p      = 4,
  parameter int coord_width_p = 10,
  parameter int color_width_p = 4
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         frame_i,
  input  logic [coord_width_p-1:0]     sx_i,
  input  logic [coord_width_p-1:0]     sy_i,
  input  logic                         de_i,
  input  logic                         hsync_i,
  input  logic                         vsync_i,
  input  logic [3*color_width_p-1:0]   bg_color_i,
  input  logic                         cfg_valid_i,
  output logic                         cfg_ready_o,
  input  logic [$clog2(layers_p)-1:0]  cfg_layer_i,
  input  logic [coord_width_p-1:0]     cfg_left_i,
  input  logic [coord_width_p-1:0]     cfg_right_i,
  input  logic [coord_width_p-1:0]     cfg_top_i,
  input  logic [coord_width_p-1:0]     cfg_bot_i,
  input  logic [3*color_width_p-1:0]   cfg_color_i,
  input  logic                         cfg_enable_i,
  output logic [color_width_p-1:0]     r_o,
  output logic [color_width_p-1:0]     g_o,
  output logic [color_width_p-1:0]     b_o,
  output logic                         de_o,
  output logic                         hsync_o,
  output logic                         vsync_o,
  output logic [layers_p-1:0]          collide_o,
  output logic                         collide_valid_o
);

  localparam int sel_width_c = $clog2(layers_p);

  logic                       cfg_write_s;
  logic [layers_p-1:0]        hit_s;
  color_t                     layer_color_s [layers_p];
  logic [2:0]                 timing_pipe_r [mixer_latency_c];
  logic [3*color_width_p-1:0] bg_r;
  color_t                     bg_color_s;
  color_t                     sel_color_s;
  logic                       de_d1_s;
  logic [layers_p-1:0]        acc_r;
  logic [layers_p-1:0]        acc_next_s;

  // Writes are refused on the commit cycle so shadow and active never race.
  assign cfg_ready_o = reset_n_i && !frame_i;
  assign cfg_write_s = cfg_valid_i && cfg_ready_o;

  for (genvar i = 0; i < layers_p; i++) begin : g_slot
    layer_slot #(
      .layer_idx_p  (i),
      .coord_width_p(coord_width_p),
      .color_width_p(color_width_p),
      .sel_width_p  (sel_width_c)
    ) u_slot (
      .clk_i       (clk_i),
      .reset_n_i   (reset_n_i),
      .frame_i     (frame_i),
      .cfg_write_i (cfg_write_s),
      .cfg_layer_i (cfg_layer_i),
      .cfg_left_i  (cfg_left_i),
      .cfg_right_i (cfg_right_i),
      .cfg_top_i   (cfg_top_i),
      .cfg_bot_i   (cfg_bot_i),
      .cfg_color_i (cfg_color_i),
      .cfg_enable_i(cfg_enable_i),
      .sx_i        (sx_i),
      .sy_i        (sy_i),
      .hit_o       (hit_s[i]),
      .color_o     (layer_color_s[i])
    );
  end

  // Timing delay line; its depth must equal the two colour stages below.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      for (int k = 0; k < mixer_latency_c; k++) timing_pipe_r[k] <= 3'b000;
    end else begin
      timing_pipe_r[0] <= {de_i, hsync_i, vsync_i};
      for (int k = 1; k < mixer_latency_c; k++) timing_pipe_r[k] <= timing_pipe_r[k-1];
    end
  end

  assign de_d1_s = timing_pipe_r[0][2];
  assign de_o    = timing_pipe_r[mixer_latency_c-1][2];
  assign hsync_o = timing_pipe_r[mixer_latency_c-1][1];
  assign vsync_o = timing_pipe_r[mixer_latency_c-1][0];

  // Stage-1 background register keeps bg aligned with the hit vector.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      bg_r <= '0;
    end else begin
      bg_r <= bg_color_i;
    end
  end

  // Priority select: scan high to low so the lowest hitting index wins.
  always_comb begin
    bg_color_s   = '0;
    bg_color_s.r = color_max_width_c'(bg_r[3*color_width_p-1 -: color_width_p]);
    bg_color_s.g = color_max_width_c'(bg_r[2*color_width_p-1 -: color_width_p]);
    bg_color_s.b = color_max_width_c'(bg_r[color_width_p-1:0]);
    sel_color_s  = bg_color_s;
    for (int i = layers_p - 1; i >= 0; i--) begin
      if (hit_s[i]) sel_color_s = layer_color_s[i];
      else          sel_color_s = sel_color_s;
    end
  end

  // Stage-2 colour outputs, blanked outside the active area.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_o <= '0;
      g_o <= '0;
      b_o <= '0;
    end else if (de_d1_s) begin
      r_o <= color_width_p'(sel_color_s.r);
      g_o <= color_width_p'(sel_color_s.g);
      b_o <= color_width_p'(sel_color_s.b);
    end else begin
      r_o <= '0;
      g_o <= '0;
      b_o <= '0;
    end
  end

  // Visible pixel with two or more hitting layers marks every hitting layer.
  always_comb begin
    if (de_d1_s && ((hit_s & (hit_s - layers_p'(1))) != '0)) acc_next_s = acc_r | hit_s;
    else                                                      acc_next_s = acc_r;
  end

  // Publish and clear the accumulator at the frame strobe.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      acc_r           <= '0;
      collide_o       <= '0;
      collide_valid_o <= 1'b0;
    end else begin
      collide_valid_o <= frame_i;
      if (frame_i) begin
        collide_o <= acc_next_s;
        acc_r     <= '0;
      end else begin
        acc_r     <= acc_next_s;
      end
    end
  end

endmodule
